// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hits return combinationally; misses refill a whole line over the
// mem_req/mem_ready handshake and stores are written through to memory.
// Optional feature macro: DCACHE_STATS_EN adds hit_count/miss_count outputs.
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  output logic [DATA_WIDTH-1:0] cpu_rd,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int TAG_LSB  = IDX_BITS + OFF_BITS + 2;
  localparam int TAG_BITS = DATA_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]     valid;
  logic [TAG_BITS-1:0] tag_array  [SETS];
  logic [DATA_WIDTH-1:0] data_array [SETS*WORDS_PER_LINE];

  logic [OFF_BITS-1:0] refill_cnt;
  logic                last_word;

  logic [IDX_BITS-1:0] cpu_idx;
  logic [OFF_BITS-1:0] cpu_off;
  logic [TAG_BITS-1:0] cpu_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic                hit;
  logic                unused_addr_bits;

  assign cpu_off  = cpu_addr[OFF_BITS+1:2];
  assign cpu_idx  = cpu_addr[TAG_LSB-1:OFF_BITS+2];
  assign cpu_tag  = cpu_addr[DATA_WIDTH-1:TAG_LSB];
  // The refill target comes from the line address being fetched; its index
  // and tag fields never change because the offset never wraps.
  assign fill_idx = mem_addr[TAG_LSB-1:OFF_BITS+2];
  assign fill_tag = mem_addr[DATA_WIDTH-1:TAG_LSB];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign hit       = valid[cpu_idx] && (tag_array[cpu_idx] == cpu_tag);
  assign cpu_rd    = hit ? data_array[{cpu_idx, cpu_off}] : '0;
  assign last_word = (refill_cnt == OFF_BITS'(WORDS_PER_LINE - 1));

  // Next-state decode plus stall and memory handshake outputs
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        stall = cpu_we | (cpu_re & ~hit);
        if (cpu_we)
          state_nxt = WRITE;
        else if (cpu_re && !hit)
          state_nxt = REFILL;
      end
      REFILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready && last_word)
          state_nxt = IDLE;
      end
      WRITE: begin
        stall   = ~mem_ready;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, request registers, refill counter and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wd     <= '0;
      refill_cnt <= '0;
      valid      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_we) begin
            mem_addr <= {cpu_addr[DATA_WIDTH-1:2], 2'b00};
            mem_wd   <= cpu_wd;
          end else if (cpu_re && !hit) begin
            mem_addr   <= {cpu_addr[DATA_WIDTH-1:OFF_BITS+2], {(OFF_BITS+2){1'b0}}};
            refill_cnt <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            refill_cnt <= refill_cnt + OFF_BITS'(1);
            mem_addr   <= mem_addr + DATA_WIDTH'(4);
            if (last_word)
              valid[fill_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag storage (not reset); refill words and write-through hits
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      data_array[{fill_idx, refill_cnt}] <= mem_rd;
      if (last_word)
        tag_array[fill_idx] <= fill_tag;
    end
    if (state == WRITE && mem_ready && hit)
      data_array[{cpu_idx, cpu_off}] <= cpu_wd;
  end

`ifdef DCACHE_STATS_EN
  // Load hit and miss statistics; both wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (cpu_re && !cpu_we && hit)
        hit_count <= hit_count + 32'd1;
      if (!cpu_we && cpu_re && !hit)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized
// loads/stores against a cache-occupancy model and a backing-memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_ready;
  logic [31:0] mem_rd;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache #(.DATA_WIDTH(32), .SETS(64), .WORDS_PER_LINE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: explicit contents or a fixed hash of the address
  logic [31:0] bmem [bit [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h9E3779B1) ^ 32'h0BAD_F00D;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } txn_t;
  txn_t log_q[$];

  // Cache occupancy model: which tag each set holds
  bit        mvalid [64];
  bit [21:0] mtag   [64];
  int        n_loads = 0;
  int        n_miss  = 0;

  // Memory responder: waits wait_cfg cycles per word, checks request stability
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [31:0] h_addr, h_wd;
  logic        h_we;
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        h_addr = mem_addr;
        h_wd   = mem_wd;
        h_we   = mem_we;
      end else begin
        check("hold_addr", mem_addr, h_addr);
        check("hold_wd", mem_wd, h_wd);
        check("hold_we", {31'd0, mem_we}, {31'd0, h_we});
      end
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        wcnt = 0;
        log_q.push_back('{we: mem_we, addr: mem_addr, wd: mem_wd});
        if (mem_we) bmem[mem_addr] = mem_wd;
        else mem_rd = mem_word(mem_addr);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end
  end

  // One CPU access, held until stall drops; checks latency, traffic and data
  task automatic access(input bit is_store, input logic [31:0] addr,
                        input logic [31:0] wd, input int w);
    logic [31:0] wa, base, exp_rd;
    logic [5:0]  idx;
    logic [21:0] tag;
    bit          hit;
    int          nst, exp_stall, exp_txn;
    wa   = {addr[31:2], 2'b00};
    base = {addr[31:4], 4'h0};
    idx  = addr[9:4];
    tag  = addr[31:10];
    hit  = mvalid[idx] && (mtag[idx] == tag);
    exp_rd = mem_word(wa);
    if (is_store) begin
      exp_stall = 1 + w;
      exp_txn   = 1;
    end else if (hit) begin
      exp_stall = 0;
      exp_txn   = 0;
    end else begin
      exp_stall = 4 * (w + 1) + 1;
      exp_txn   = 4;
    end
    @(negedge clk);
    wait_cfg = w;
    log_q.delete();
    cpu_re   = !is_store;
    cpu_we   = is_store;
    cpu_addr = addr;
    cpu_wd   = wd;
    #1;
    nst = 0;
    while (stall && nst < 200) begin
      nst++;
      @(negedge clk);
      #1;
    end
    check(is_store ? "st_stall" : "ld_stall", nst, exp_stall);
    if (!is_store) check("ld_data", cpu_rd, exp_rd);
    check("txn_count", log_q.size(), exp_txn);
    for (int i = 0; i < log_q.size() && i < exp_txn; i++) begin
      if (is_store) begin
        check("wr_we", {31'd0, log_q[i].we}, 32'd1);
        check("wr_addr", log_q[i].addr, wa);
        check("wr_data", log_q[i].wd, wd);
      end else begin
        check("rd_we", {31'd0, log_q[i].we}, 32'd0);
        check("rd_addr", log_q[i].addr, base + 32'(4 * i));
      end
    end
    if (!is_store) begin
      n_loads++;
      if (!hit) begin
        n_miss++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] bases [3];
    bases[0] = 32'h0001_0000;
    bases[1] = 32'h0001_0400;
    bases[2] = 32'h0002_0000;
    return bases[$urandom_range(2, 0)] + 32'($urandom_range(3, 0) << 4)
         + 32'($urandom_range(3, 0) << 2) + 32'($urandom_range(3, 0));
  endfunction

  initial begin
    rst = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
    mem_ready = 1'b0; mem_rd = '0;
    bmem[32'h0001_0000] = 32'h11;
    bmem[32'h0001_0004] = 32'h22;
    bmem[32'h0001_0008] = 32'h33;
    bmem[32'h0001_000C] = 32'h44;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, then hit in the same line
    access(1'b0, 32'h0001_0000, '0, 0);
    check("s1_rd_const", cpu_rd, 32'h11);
    access(1'b0, 32'h0001_000C, '0, 0);
    check("s1_hit_const", cpu_rd, 32'h44);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    cpu_re = 1'b0;
    #1;
    check("stat_miss", miss_count, 32'd1);
    check("stat_hit", hit_count, 32'd2);
`endif
    // Store hit updates cache and memory
    access(1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h0001_0004, '0, 0);
    check("s2_rd_const", cpu_rd, 32'hDEAD_BEEF);
    // Conflict eviction in set 0
    access(1'b0, 32'h0001_0400, '0, 0);
    access(1'b0, 32'h0001_0000, '0, 0);
    // Store miss does not allocate
    access(1'b1, 32'h0002_0000, 32'h5, 0);
    access(1'b0, 32'h0002_0000, '0, 0);
    check("s4_rd_const", cpu_rd, 32'h5);
    // Slow store with request held stable
    access(1'b1, 32'h0002_0000, 32'h1234_5678, 3);
    access(1'b0, 32'h0002_0000, '0, 1);

    // Randomized loads and stores with random memory wait states
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(9, 0) < 4)
        access(1'b1, rand_addr(), $urandom, $urandom_range(2, 0));
      else
        access(1'b0, rand_addr(), '0, $urandom_range(2, 0));
    end

    // Reset in the middle of a refill
    @(negedge clk);
    wait_cfg = 0;
    log_q.delete();
    cpu_we = 1'b0;
    cpu_re = 1'b1;
    cpu_addr = 32'h0003_0000;
    for (int i = 0; i < 50 && log_q.size() < 2; i++) @(posedge clk);
    check("s6_words_before_rst", log_q.size(), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("s6_req_drop", {31'd0, mem_req}, 32'd0);
    cpu_re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    access(1'b0, 32'h0001_0000, '0, 0);
    access(1'b0, 32'h0003_0000, '0, 0);

    @(negedge clk);
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
